viterbi_ber_checker: RTL and testbench

// Receive-end bit-error-rate checker for the encoder -> channel -> Viterbi decoder chain.
// - Keeps a history of transmitted bits taken at the encoder input.
// - Finds the decoder's latency, measured in transmitted bits, by correlating the decoded stream against that history.
// - Once locked, counts compared bits and bit errors.
// - Sits next to the decoder in the tx/rx top level and replaces ad-hoc $display error tallies.

---
 rtl/viterbi_ber_checker.sv | 133 +++++++++++++
 tb/tb_viterbi_ber_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for the encoder -> channel -> Viterbi decoder chain.
// Finds decoder latency (in tx bits) by correlation, then counts compared bits and errors.
module viterbi_ber_checker #(
  parameter int unsigned MAX_LAT     = 32,
  parameter int unsigned SYNC_LEN    = 16,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CW          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_valid_i,
  input  logic                       tx_bit_i,
  input  logic                       rx_valid_i,
  input  logic                       rx_bit_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [CW-1:0]              bit_ct_o,
  output logic [CW-1:0]              err_ct_o,
  output logic                       sync_loss_o
);

  localparam int unsigned LW = $clog2(MAX_LAT);
  localparam int unsigned MW = $clog2(SYNC_LEN + 1);
  localparam int unsigned SW = $clog2(LOSS_THRESH + 1);

  typedef enum logic {StSearch, StLocked} state_e;

  state_e              state_q, state_d;
  logic [MAX_LAT-1:0]  hist_q, hist_d;
  logic [LW-1:0]       lat_q, lat_d, lat_next;
  logic [MW-1:0]       match_q, match_d;
  logic [SW-1:0]       miss_q, miss_d;
  logic [CW-1:0]       bit_q, bit_d, err_q, err_d;
  logic                loss_q, loss_d;
  logic                hit, bit_sat, err_sat;

  // Reference is always the pre-shift history at the current candidate.
  assign hit      = (rx_bit_i == hist_q[lat_q]);
  assign bit_sat  = &bit_q;
  assign err_sat  = &err_q;
  assign lat_next = (lat_q == LW'(MAX_LAT - 1)) ? '0 : lat_q + LW'(1);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    lat_d   = lat_q;
    match_d = match_q;
    miss_d  = miss_q;
    bit_d   = bit_q;
    err_d   = err_q;
    loss_d  = 1'b0;

    if (tx_valid_i) begin
      hist_d = {hist_q[MAX_LAT-2:0], tx_bit_i};
    end

    if (rx_valid_i) begin
      unique case (state_q)
        StSearch: begin
          if (hit) begin
            if (match_q == MW'(SYNC_LEN - 1)) begin
              state_d = StLocked;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
            lat_d   = lat_next;
          end
        end
        StLocked: begin
          if (!bit_sat) begin
            bit_d = bit_q + CW'(1);
          end
          if (hit) begin
            miss_d = '0;
          end else begin
            // Error count freezes together with the bit count at saturation.
            if (!bit_sat && !err_sat) begin
              err_d = err_q + CW'(1);
            end
            if (miss_q == SW'(LOSS_THRESH - 1)) begin
              state_d = StSearch;
              loss_d  = 1'b1;
              lat_d   = lat_next;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + SW'(1);
            end
          end
        end
      endcase
    end

    if (clear_i) begin
      bit_d = '0;
      err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSearch;
      hist_q  <= '0;
      lat_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      bit_q   <= '0;
      err_q   <= '0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      lat_q   <= lat_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
    end
  end

  assign locked_o    = (state_q == StLocked);
  assign latency_o   = lat_q;
  assign bit_ct_o    = bit_q;
  assign err_ct_o    = err_q;
  assign sync_loss_o = loss_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: table of lock scenarios plus hand-written
// error-injection, loss/relock, clear, saturation (CW=4 instance) and mid-lock reset sequences.
module tb_viterbi_ber_checker;

  localparam int MAX_LAT  = 32;
  localparam int SYNC_LEN = 16;

  logic        clk = 1'b0;
  logic        rst, tx_valid, tx_bit, rx_valid, rx_bit, clear;
  logic        locked, sync_loss, locked4, sync_loss4;
  logic [4:0]  latency, latency4;
  logic [31:0] bit_ct, err_ct;
  logic [3:0]  bit_ct4, err_ct4;

  always #5 clk = ~clk;

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .SYNC_LEN(SYNC_LEN), .LOSS_THRESH(8), .CW(32)) dut (
    .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit), .rx_valid_i(rx_valid),
    .rx_bit_i(rx_bit), .clear_i(clear), .locked_o(locked), .latency_o(latency),
    .bit_ct_o(bit_ct), .err_ct_o(err_ct), .sync_loss_o(sync_loss)
  );

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .SYNC_LEN(SYNC_LEN), .LOSS_THRESH(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit), .rx_valid_i(rx_valid),
    .rx_bit_i(rx_bit), .clear_i(clear), .locked_o(locked4), .latency_o(latency4),
    .bit_ct_o(bit_ct4), .err_ct_o(err_ct4), .sync_loss_o(sync_loss4)
  );

  typedef struct {
    int period;
    int lag;
    int exp_lat;
    bit sparse;
  } vec_t;

  vec_t       vecs[4];
  int         errors = 0;
  int         checks = 0;
  int         tx_period, rx_lag, cyc, rx_sent, pulses;
  bit         sparse;
  logic [6:0] prbs;
  bit         txq[$];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: tx every tx_period cycles from PRBS7, rx = tx bit rx_lag accepted bits back.
  task automatic step(input bit want_rx, input bit inv, input bit clr);
    bit txv, rxv, rb;
    txv = (cyc % tx_period) == 0;
    rxv = want_rx && (txq.size() >= rx_lag) && (!sparse || $urandom_range(0, 2) == 0);
    rb  = rxv ? (txq[txq.size() - rx_lag] ^ inv) : 1'b0;
    tx_valid = txv;
    tx_bit   = prbs[6];
    rx_valid = rxv;
    rx_bit   = rb;
    clear    = clr;
    @(posedge clk);
    if (txv) begin
      txq.push_back(prbs[6]);
      if (txq.size() > 64) void'(txq.pop_front());
      prbs = {prbs[5:0], prbs[6] ^ prbs[5]};
    end
    cyc++;
    if (rxv) rx_sent++;
    #1;
    if (sync_loss) pulses++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0; tx_bit = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    txq.delete();
    cyc  = 0;
    prbs = 7'h7f;
  endtask

  task automatic run_lock(input int period, input int lag, input int exp_lat, input bit sp);
    bit got;
    tx_period = period;
    rx_lag    = lag;
    sparse    = sp;
    repeat (40 * period) step(1'b0, 1'b0, 1'b0);
    rx_sent = 0;
    got     = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      step(1'b1, 1'b0, 1'b0);
      got = locked;
    end
    chk("lock_reached", got, 1);
    chk("lock_latency", latency, exp_lat);
    chk("lock_rx_budget", rx_sent <= MAX_LAT * SYNC_LEN, 1);
    chk("search_bits_frozen", bit_ct, 0);
    chk("search_errs_frozen", err_ct, 0);
  endtask

  initial begin
    bit got;
    vecs[0] = '{period: 1, lag: 5,  exp_lat: 4,  sparse: 1'b0};
    vecs[1] = '{period: 3, lag: 2,  exp_lat: 1,  sparse: 1'b1};
    vecs[2] = '{period: 1, lag: 1,  exp_lat: 0,  sparse: 1'b0};
    vecs[3] = '{period: 2, lag: 32, exp_lat: 31, sparse: 1'b0};
    tx_period = 1; rx_lag = 1; sparse = 1'b0; rx_sent = 0; pulses = 0;

    rst = 1'b1;
    tx_valid = 1'b0; tx_bit = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_latency", latency, 0);
    chk("reset_bit_ct", bit_ct, 0);
    chk("reset_err_ct", err_ct, 0);
    chk("reset_sync_loss", sync_loss, 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      run_lock(vecs[v].period, vecs[v].lag, vecs[v].exp_lat, vecs[v].sparse);
      rx_sent = 0;
      repeat (20) step(1'b1, 1'b0, 1'b0);
      chk("locked_bit_ct", bit_ct, rx_sent);
      chk("locked_err_ct", err_ct, 0);
      chk("locked_held", locked, 1);
    end

    // Clear coincident with an erroneous rx bit: nothing counted.
    do_reset();
    run_lock(1, 5, 4, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clear_bit_ct", bit_ct, 0);
    chk("clear_err_ct", err_ct, 0);
    chk("clear_bit_ct4", bit_ct4, 0);
    chk("clear_keeps_lock", locked, 1);

    // Every 8th bit inverted, last bits clean.
    pulses = 0;
    for (int i = 0; i < 800; i++) begin
      step(1'b1, (i % 8) == 0, 1'b0);
      if (i == 19) begin
        chk("sat_bit_ct4", bit_ct4, 15);
        chk("sat_err_ct4", err_ct4, 2);
      end
    end
    chk("inj_bit_ct", bit_ct, 800);
    chk("inj_err_ct", err_ct, 100);
    chk("inj_locked", locked, 1);
    chk("inj_no_loss", pulses, 0);
    chk("sat_hold_bit_ct4", bit_ct4, 15);
    chk("sat_hold_err_ct4", err_ct4, 2);
    chk("sat_locked4", locked4, 1);

    // Eight consecutive errors drop lock on the eighth.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 6) chk("loss_not_yet", locked, 1);
    end
    chk("loss_locked", locked, 0);
    chk("loss_pulse", sync_loss, 1);
    chk("loss_latency", latency, 5);
    chk("loss_bit_ct", bit_ct, 808);
    chk("loss_err_ct", err_ct, 108);

    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      step(1'b1, 1'b0, 1'b0);
      got = locked;
    end
    chk("relock_reached", got, 1);
    chk("relock_latency", latency, 4);
    chk("relock_bit_ct", bit_ct, 808);
    chk("relock_err_ct", err_ct, 108);
    chk("loss_pulse_count", pulses, 1);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("resume_bit_ct", bit_ct, 818);
    chk("resume_err_ct", err_ct, 108);

    // Reset while locked, with an rx bit in flight.
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_locked", locked, 0);
    chk("midrst_latency", latency, 0);
    chk("midrst_bit_ct", bit_ct, 0);
    chk("midrst_err_ct", err_ct, 0);
    chk("midrst_sync_loss", sync_loss, 0);
    chk("midrst_bit_ct4", bit_ct4, 0);
    chk("midrst_latency4", latency4, 0);
    chk("midrst_sync_loss4", sync_loss4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
